// File: rtl/record_serializer_pkg.sv
// record_serializer_pkg: FSM states, ASCII constants, record struct and hex helpers; SERIALIZER_UPPER_HEX_EN selects uppercase hex
package record_serializer_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;
  localparam int TIME_MAX_DEF = 9999;
  localparam logic [7:0] C_CARET  = 8'h5e;
  localparam logic [7:0] C_AT     = 8'h40;
  localparam logic [7:0] C_COLON  = 8'h3a;
  localparam logic [7:0] C_DOLLAR = 8'h24;
  localparam logic [7:0] C_STAR   = 8'h2a;
  localparam logic [7:0] C_LT     = 8'h3c;
  localparam logic [7:0] C_EQ     = 8'h3d;
  localparam logic [7:0] C_HASH   = 8'h23;
  localparam logic [7:0] C_SPACE  = 8'h20;
  typedef struct packed {
    logic        kind;
    logic [4:0]  rg;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } rec_t;
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
`ifdef SERIALIZER_UPPER_HEX_EN
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
`else
    return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
`endif
  endfunction
  function automatic logic [3:0] hex_nib(input logic [31:0] w, input logic [2:0] n);
    logic [31:0] s;
    s = w >> {n, 2'b00};
    return s[3:0];
  endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter; start loads bin, done is high in the cycle whose edge completes bcd (4 digits)
module bin2bcd_seq #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] bin,
  output logic         done,
  output logic [15:0]  bcd
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0]  sr;
  logic [CW-1:0] cnt;
  logic [15:0]   adj;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < 4; i++) adj[4*i +: 4] = bcd[4*i +: 4] > 4'd4 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  assign done = cnt == CW'(1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr  <= '0;
      bcd <= '0;
      cnt <= '0;
    end else if (start) begin
      sr  <= bin;
      bcd <= '0;
      cnt <= CW'(W);
    end else if (cnt != '0) begin
      {bcd, sr} <= {adj, sr} << 1;
      cnt       <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/record_serializer.sv
// record_serializer: serializes one write-back record per handshake into ASCII on char (ports: clk, reset, rec_* in, rec_ready/char/char_valid/busy out; SERIALIZER_UPPER_HEX_EN = uppercase hex)
module record_serializer
  import record_serializer_pkg::*;
#(
  parameter int TIME_W   = 14,
  parameter int TIME_MAX = TIME_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rec_valid,
  output logic              rec_ready,
  input  logic              rec_kind,
  input  logic [TIME_W-1:0] rec_time,
  input  logic [31:0]       rec_pc,
  input  logic [4:0]        rec_reg,
  input  logic [31:0]       rec_addr,
  input  logic [31:0]       rec_data,
  output logic [7:0]        char,
  output logic              char_valid,
  output logic              busy
);
  logic [1:0]        state;
  logic [5:0]        idx;
  rec_t              r;
  logic              accept;
  logic              conv_done;
  logic [15:0]       bcd;
  logic [TIME_W-1:0] t_clamp;
  logic [2:0]        td;
  logic [3:0]        fl;
  logic [3:0]        tens;
  logic [3:0]        ones;
  logic [5:0]        t6;
  logic [5:0]        f0;
  logic [5:0]        e0;
  logic [5:0]        len;
  logic [7:0]        ch;
  assign rec_ready = state == ST_IDLE;
  assign busy      = !rec_ready;
  assign accept    = rec_valid && rec_ready;
  assign t_clamp   = rec_time > TIME_W'(TIME_MAX) ? TIME_W'(TIME_MAX) : rec_time;
  bin2bcd_seq #(.W(TIME_W)) u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (accept),
    .bin   (t_clamp),
    .done  (conv_done),
    .bcd   (bcd)
  );
  // f0: first field character, e0: space after the field, len: index one past '#'
  always_comb begin
    td   = bcd[15:12] != 4'd0 ? 3'd4 : bcd[11:8] != 4'd0 ? 3'd3 : bcd[7:4] != 4'd0 ? 3'd2 : 3'd1;
    tens = r.rg >= 5'd30 ? 4'd3 : r.rg >= 5'd20 ? 4'd2 : r.rg >= 5'd10 ? 4'd1 : 4'd0;
    ones = 4'(r.rg - 5'(tens) * 5'd10);
    fl   = r.kind ? 4'd8 : tens != 4'd0 ? 4'd2 : 4'd1;
    t6   = 6'(td);
    f0   = t6 + 6'd13;
    e0   = f0 + 6'(fl);
    len  = e0 + 6'd13;
    ch   = idx == 6'd0 ? C_CARET :
           idx <= t6 ? nibble_to_ascii(hex_nib({16'h0, bcd}, 3'(t6 - idx))) :
           idx == t6 + 6'd1 ? C_AT :
           idx <= t6 + 6'd9 ? nibble_to_ascii(hex_nib(r.pc, 3'(t6 + 6'd9 - idx))) :
           idx == t6 + 6'd10 ? C_COLON :
           idx == t6 + 6'd11 ? C_SPACE :
           idx == t6 + 6'd12 ? (r.kind ? C_STAR : C_DOLLAR) :
           idx < e0 ? (r.kind ? nibble_to_ascii(hex_nib(r.addr, 3'(f0 + 6'd7 - idx)))
                              : nibble_to_ascii(idx == f0 && tens != 4'd0 ? tens : ones)) :
           idx == e0 || idx == e0 + 6'd3 ? C_SPACE :
           idx == e0 + 6'd1 ? C_LT :
           idx == e0 + 6'd2 ? C_EQ :
           idx < e0 + 6'd12 ? nibble_to_ascii(hex_nib(r.data, 3'(e0 + 6'd11 - idx))) :
           C_HASH;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      r          <= '0;
      char       <= '0;
      char_valid <= 1'b0;
    end else if (state == ST_IDLE) begin
      char       <= '0;
      char_valid <= 1'b0;
      if (rec_valid) begin
        r     <= '{kind: rec_kind, rg: rec_reg, pc: rec_pc, addr: rec_addr, data: rec_data};
        state <= ST_CONV;
      end
    end else if (state == ST_CONV) begin
      idx <= '0;
      if (conv_done) state <= ST_EMIT;
    end else if (state == ST_EMIT) begin
      char       <= idx == len ? 8'h00 : ch;
      char_valid <= idx != len;
      idx        <= idx + 6'd1;
      if (idx == len) state <= ST_IDLE;
    end else begin
      state <= ST_IDLE;
    end
  end
endmodule
